// File: rtl/prio_enc_queue.sv
// Pending-request priority encoder: latches Din into a pending vector, presents the winning index, retires it on Ack.
// Optional ENC_ROUND_ROBIN_EN macro selects rotating priority; the default build uses fixed lowest-index priority.
module prio_enc_queue #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           En,
    input  logic [N-1:0]   Din,
    input  logic           Ack,
    output logic [W-1:0]   Do,
    output logic           Valid,
    output logic [W:0]     Pend_cnt
);

    logic [N-1:0] p_q, p_d;
    logic [N-1:0] clr;
    logic [W-1:0] win;
    logic [W:0]   cnt;

    assign Valid = |p_q;
    assign Do    = win;
    assign clr   = (Valid && Ack) ? ({{(N-1){1'b0}}, 1'b1} << Do) : '0;

    // Set wins over clear when the acked line is re-requested on the same edge
    assign p_d = (p_q & ~clr) | (En ? Din : '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + (W+1)'(p_q[i]);
        end
    end
    assign Pend_cnt = cnt;

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic         found;
    int           idx;

    // Search upward from ptr_q, wrapping N-1 -> 0; ptr_q always stays below N
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && p_q[idx]) begin
                found = 1'b1;
                win   = W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (Valid && Ack) begin
            ptr_d = (Do == W'(N-1)) ? '0 : Do + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Scanning downward leaves the lowest set index as the winner
    always_comb begin
        win = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (p_q[i]) begin
                win = W'(i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_prio_enc_queue.sv
// Directed bench for prio_enc_queue with N=8, N=4 and N=5 instances; expectations follow ENC_ROUND_ROBIN_EN.
module tb_prio_enc_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en8 = 0, ack8 = 0;
    logic [7:0] din8 = '0;
    logic [2:0] do8;
    logic       v8;
    logic [3:0] cnt8;

    logic       en4 = 0, ack4 = 0;
    logic [3:0] din4 = '0;
    logic [1:0] do4;
    logic       v4;
    logic [2:0] cnt4;

    logic       en5 = 0, ack5 = 0;
    logic [4:0] din5 = '0;
    logic [2:0] do5;
    logic       v5;
    logic [3:0] cnt5;

    prio_enc_queue #(.N(8)) u8 (.Clk(clk), .Rst_n(rst_n), .En(en8), .Din(din8), .Ack(ack8),
                                .Do(do8), .Valid(v8), .Pend_cnt(cnt8));
    prio_enc_queue #(.N(4)) u4 (.Clk(clk), .Rst_n(rst_n), .En(en4), .Din(din4), .Ack(ack4),
                                .Do(do4), .Valid(v4), .Pend_cnt(cnt4));
    prio_enc_queue #(.N(5)) u5 (.Clk(clk), .Rst_n(rst_n), .En(en5), .Din(din5), .Ack(ack5),
                                .Do(do5), .Valid(v5), .Pend_cnt(cnt5));

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic       ack;
        logic       v;
        logic [2:0] dout;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[11];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // N=8 sequence: multi-request drain, ack on empty, set-beats-clear, full/merge
        vecs[0]  = '{1, 8'b1001_0110, 0, 1, 3'd1, 4'd4};
        vecs[1]  = '{0, 8'b0000_0000, 1, 1, 3'd2, 4'd3};
        vecs[2]  = '{0, 8'b0000_0000, 1, 1, 3'd4, 4'd2};
        vecs[3]  = '{0, 8'b0000_0000, 1, 1, 3'd7, 4'd1};
        vecs[4]  = '{0, 8'b0000_0000, 1, 0, 3'd0, 4'd0};
        vecs[5]  = '{0, 8'b0000_0000, 1, 0, 3'd0, 4'd0};
        vecs[6]  = '{1, 8'b0000_1000, 0, 1, 3'd3, 4'd1};
        vecs[7]  = '{1, 8'b0000_1000, 1, 1, 3'd3, 4'd1};
`ifdef ENC_ROUND_ROBIN_EN
        vecs[8]  = '{1, 8'b1111_1111, 0, 1, 3'd4, 4'd8};
        vecs[9]  = '{1, 8'b0000_0001, 0, 1, 3'd4, 4'd8};
        vecs[10] = '{0, 8'b0000_0000, 1, 1, 3'd5, 4'd7};
`else
        vecs[8]  = '{1, 8'b1111_1111, 0, 1, 3'd0, 4'd8};
        vecs[9]  = '{1, 8'b0000_0001, 0, 1, 3'd0, 4'd8};
        vecs[10] = '{0, 8'b0000_0000, 1, 1, 3'd1, 4'd7};
`endif

        #1;
        check("rst_valid", v8, 0);
        check("rst_do", do8, 0);
        check("rst_cnt", cnt8, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            en8 = vecs[i].en; din8 = vecs[i].din; ack8 = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_valid", i), v8, vecs[i].v);
            check($sformatf("vec%0d_do", i), do8, vecs[i].dout);
            check($sformatf("vec%0d_cnt", i), cnt8, vecs[i].cnt);
        end
        en8 = 0; din8 = '0; ack8 = 0;

        // Asynchronous reset between edges with requests pending
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", v8, 0);
        check("async_rst_do", do8, 0);
        check("async_rst_cnt", cnt8, 0);
        #1 rst_n = 1'b1;
        en8 = 1; din8 = 8'b0010_0000;
        tick();
        check("post_rst_do", do8, 5);
        check("post_rst_cnt", cnt8, 1);

        // Lines 1 and 6 re-requested every cycle with Ack held
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        en8 = 1; din8 = 8'b0100_0010; ack8 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef ENC_ROUND_ROBIN_EN
            check($sformatf("rr%0d_do", i), do8, (i % 2 == 0) ? 1 : 6);
`else
            check($sformatf("rr%0d_do", i), do8, 1);
`endif
            check($sformatf("rr%0d_cnt", i), cnt8, 2);
        end
        en8 = 0; din8 = '0; ack8 = 0;

        // Legacy one-hot on N=4, acked every cycle
        en4 = 1; ack4 = 1;
        for (int i = 0; i < 4; i++) begin
            din4 = 4'b0001 << i;
            tick();
            check($sformatf("n4_%0d_do", i), do4, i);
            check($sformatf("n4_%0d_valid", i), v4, 1);
            check($sformatf("n4_%0d_cnt", i), cnt4, 1);
        end
        en4 = 0; din4 = '0;
        tick();
        check("n4_drained_valid", v4, 0);
        ack4 = 0;

        // N=5: Ack while empty is ignored, then top line
        ack5 = 1;
        tick();
        check("n5_ack_empty_valid", v5, 0);
        check("n5_ack_empty_cnt", cnt5, 0);
        ack5 = 0; en5 = 1; din5 = 5'b10000;
        tick();
        check("n5_top_do", do5, 4);
        check("n5_top_cnt", cnt5, 1);
        en5 = 0; din5 = '0; ack5 = 1;
        tick();
        check("n5_drain_valid", v5, 0);
        check("n5_drain_do", do5, 0);
        ack5 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
